// File: rtl/pipe_out_arbiter.sv
// Block-granular round-robin arbiter sharing one 16-bit pipe-out endpoint between NSRC source FIFOs.
// Optional feature: define PIPE_OUT_ARB_TAG_EN to prepend a {grant, seq} tag word to every block.
module pipe_out_arbiter #(
    parameter int unsigned NSRC        = 4,
    parameter int unsigned BLOCK_WORDS = 256,
    parameter int unsigned LEVEL_W     = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NSRC-1:0]           src_en,
    input  logic [NSRC*LEVEL_W-1:0]   src_level,
    output logic [NSRC-1:0]           src_rd,
    input  logic [NSRC*16-1:0]        src_data,
    input  logic                      pipe_out_read,
    input  logic                      pipe_out_blockstrobe,
    output logic                      pipe_out_ready,
    output logic [15:0]               pipe_out_data,
    output logic [1:0]                grant_id,
    output logic [15:0]               block_count,
    output logic                      protocol_err
);

    localparam int unsigned CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
`ifdef PIPE_OUT_ARB_TAG_EN
    localparam int unsigned THRESH = BLOCK_WORDS - 1;
`else
    localparam int unsigned THRESH = BLOCK_WORDS;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       grant_nxt;
    logic [15:0]      bcnt_nxt;
    logic             err_nxt;
    logic             xfer_rd_c;
    logic             src_rd_ok_c;
    logic [NSRC-1:0]  eligible;
    logic             pick_found;
    logic [1:0]       pick_id;
    logic             rd_q;
    logic [1:0]       data_sel;
    logic [15:0]      sel_word;

    // A source is eligible once it holds a whole block
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            eligible[i] = src_en[i] &&
                          (src_level[i*LEVEL_W +: LEVEL_W] >= LEVEL_W'(THRESH));
        end
    end

    // Round-robin scan starting after the previous grantee, which ends up last
    always_comb begin
        pick_found = 1'b0;
        pick_id    = grant_id;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            if (!pick_found && eligible[IDX_W'((32'(grant_id) + k) % NSRC)]) begin
                pick_found = 1'b1;
                pick_id    = 2'((32'(grant_id) + k) % NSRC);
            end
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        cnt_nxt   = word_cnt;
        bcnt_nxt  = block_count;
        err_nxt   = protocol_err;
        xfer_rd_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (pipe_out_read || pipe_out_blockstrobe) begin
                    err_nxt = 1'b1;
                end
                if (enable && pick_found) begin
                    grant_nxt = pick_id;
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (pipe_out_read) begin
                    err_nxt = 1'b1;
                end
                if (pipe_out_blockstrobe) begin
                    state_nxt = S_XFER;
                    cnt_nxt   = '0;
                end else if (!enable) begin
                    state_nxt = S_IDLE;
                end
            end
            S_XFER: begin
                if (pipe_out_blockstrobe) begin
                    err_nxt = 1'b1;
                end
                if (pipe_out_read) begin
                    xfer_rd_c = 1'b1;
                    cnt_nxt   = word_cnt + CNT_W'(1);
                    if (word_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
                        bcnt_nxt  = block_count + 16'd1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef PIPE_OUT_ARB_TAG_EN
    // The first read of a block is served from the tag register, not the source
    assign src_rd_ok_c = xfer_rd_c && (word_cnt != '0);
`else
    assign src_rd_ok_c = xfer_rd_c;
`endif

    assign src_rd = src_rd_ok_c ? (NSRC'(1) << grant_id) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            grant_id       <= 2'd0;
            word_cnt       <= '0;
            block_count    <= 16'd0;
            protocol_err   <= 1'b0;
            pipe_out_ready <= 1'b0;
            rd_q           <= 1'b0;
            data_sel       <= 2'd0;
        end else begin
            state          <= state_nxt;
            grant_id       <= grant_nxt;
            word_cnt       <= cnt_nxt;
            block_count    <= bcnt_nxt;
            protocol_err   <= err_nxt;
            pipe_out_ready <= (state_nxt != S_IDLE);
            rd_q           <= xfer_rd_c;
            data_sel       <= grant_id;
        end
    end

    // Source FIFO output lands one cycle after the strobe, matching the endpoint's read latency
    always_comb begin
        sel_word = 16'd0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (data_sel == 2'(i)) begin
                sel_word = src_data[i*16 +: 16];
            end
        end
    end

`ifdef PIPE_OUT_ARB_TAG_EN
    logic        tag_sel_q;
    logic [15:0] tag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_sel_q <= 1'b0;
            tag_q     <= 16'd0;
        end else begin
            tag_sel_q <= xfer_rd_c && (word_cnt == '0);
            tag_q     <= {grant_id, 2'b00, block_count[11:0]};
        end
    end

    assign pipe_out_data = !rd_q     ? 16'd0 :
                           tag_sel_q ? tag_q : sel_word;
`else
    assign pipe_out_data = rd_q ? sel_word : 16'd0;
`endif

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Self-checking bench for pipe_out_arbiter: FIFO source models plus a scoreboard of expected read words.
// Also exercises the tag-word build when PIPE_OUT_ARB_TAG_EN is defined.
`timescale 1ns/1ps
module tb_pipe_out_arbiter;

    localparam int unsigned NSRC = 4;
    localparam int unsigned BW   = 4;
    localparam int unsigned LW   = 11;
`ifdef PIPE_OUT_ARB_TAG_EN
    localparam int unsigned THRESH = BW - 1;
`else
    localparam int unsigned THRESH = BW;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic [NSRC-1:0]      src_en = '1;
    logic [NSRC*LW-1:0]   src_level;
    logic [NSRC-1:0]      src_rd;
    logic [NSRC*16-1:0]   src_data;
    logic                 pipe_out_read = 1'b0;
    logic                 pipe_out_blockstrobe = 1'b0;
    logic                 pipe_out_ready;
    logic [15:0]          pipe_out_data;
    logic [1:0]           grant_id;
    logic [15:0]          block_count;
    logic                 protocol_err;

    pipe_out_arbiter #(.NSRC(NSRC), .BLOCK_WORDS(BW), .LEVEL_W(LW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .src_en               (src_en),
        .src_level            (src_level),
        .src_rd               (src_rd),
        .src_data             (src_data),
        .pipe_out_read        (pipe_out_read),
        .pipe_out_blockstrobe (pipe_out_blockstrobe),
        .pipe_out_ready       (pipe_out_ready),
        .pipe_out_data        (pipe_out_data),
        .grant_id             (grant_id),
        .block_count          (block_count),
        .protocol_err         (protocol_err)
    );

    always #5 clk = ~clk;

    // Source FIFO models: word n of source i is {i, 2'b00, n}; level = loaded base - words read
    int          rd_cnt   [NSRC] = '{default: 0};
    int          lvl_base [NSRC] = '{default: 0};
    logic [15:0] src_q    [NSRC] = '{default: 16'h0};

    always @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (src_rd[i]) begin
                src_q[i]  <= {2'(i), 2'b00, 12'(rd_cnt[i])};
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        src_level = '0;
        src_data  = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_level[i*LW +: LW] = LW'(lvl_base[i] - rd_cnt[i]);
            src_data[i*16 +: 16]  = src_q[i];
        end
    end

    logic [15:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        rd_prev = 1'b0;
    int          exp_n [NSRC] = '{default: 0};
    int          exp_blocks = 0;

    task automatic set_level(input int src, input int words);
        lvl_base[src] = rd_cnt[src] + words;
    endtask

    // One clock: score the word due from last cycle's read, then apply new endpoint inputs
    task automatic drive_cycle(input logic rd, input logic strobe);
        logic [15:0] exp_word;
        @(negedge clk);
        if (rd_prev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: read data %h with no expected entry", pipe_out_data);
            end else begin
                exp_word = sb.pop_front();
                if (pipe_out_data !== exp_word) begin
                    errors++;
                    $display("FAIL pipe_out_data: got %h want %h", pipe_out_data, exp_word);
                end
            end
        end
        pipe_out_read        = rd;
        pipe_out_blockstrobe = strobe;
        rd_prev              = rd;
    endtask

    task automatic read_word(input int src, input int w);
        logic [NSRC-1:0] exp_rd;
        logic [15:0]     exp_word;
        drive_cycle(1'b1, 1'b0);
        #1;
        exp_rd = NSRC'(1) << src;
`ifdef PIPE_OUT_ARB_TAG_EN
        if (w == 0) begin
            exp_rd   = '0;
            exp_word = {2'(src), 2'b00, 12'(exp_blocks)};
        end else begin
            exp_word = {2'(src), 2'b00, 12'(exp_n[src])};
            exp_n[src]++;
        end
`else
        exp_word = {2'(src), 2'b00, 12'(exp_n[src])};
        exp_n[src]++;
`endif
        checks++;
        if (src_rd !== exp_rd) begin
            errors++;
            $display("FAIL src_rd word %0d: got %b want %b", w, src_rd, exp_rd);
        end
        sb.push_back(exp_word);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            drive_cycle(1'b0, 1'b0);
            n++;
        end while (!pipe_out_ready && n < 20);
    endtask

    // Full block from the expected source: latency, grant, data, completion, ready gap
    task automatic run_block(input int src);
        int n;
        wait_ready(n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL ready_latency: got %0d cycles want 1", n);
        end
        checks++;
        if (grant_id !== 2'(src)) begin
            errors++;
            $display("FAIL grant_id: got %0d want %0d", grant_id, src);
        end
        drive_cycle(1'b0, 1'b1);
        for (int w = 0; w < int'(BW); w++) begin
            read_word(src, w);
        end
        exp_blocks++;
        drive_cycle(1'b0, 1'b0);
        checks++;
        if (block_count !== 16'(exp_blocks)) begin
            errors++;
            $display("FAIL block_count: got %0d want %0d", block_count, exp_blocks);
        end
        checks++;
        if (pipe_out_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_gap: got %b want 0", pipe_out_ready);
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive_cycle(1'b0, 1'b0);
            checks++;
            if (pipe_out_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s: pipe_out_ready got %b want 0 (cycle %0d)", name, pipe_out_ready, c);
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NSRC; i++) set_level(i, 0);
        pipe_out_read        = 1'b0;
        pipe_out_blockstrobe = 1'b0;
        src_en               = '1;
        reset                = 1'b1;
        rd_prev              = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        exp_blocks = 0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        do_reset();
        #1;
        checks++;
        if ({pipe_out_ready, grant_id, block_count, protocol_err, pipe_out_data, src_rd} !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b grant=%0d bc=%0d err=%b data=%h rd=%b want all 0",
                     pipe_out_ready, grant_id, block_count, protocol_err, pipe_out_data, src_rd);
        end
        expect_idle("empty_idle", 3);
    endtask

    task automatic test_single();
        do_reset();
        set_level(2, THRESH);
        run_block(2);
        expect_idle("single_drained", 3);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < NSRC; i++) set_level(i, 8);
        for (int b = 0; b < 8; b++) run_block((b + 1) % NSRC);
        expect_idle("rr_drained", 3);
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL rr_protocol_err: got %b want 0", protocol_err);
        end
    endtask

    task automatic test_mask();
        int order [6] = '{1, 3, 0, 1, 3, 0};
        do_reset();
        src_en = 4'b1011;
        for (int i = 0; i < NSRC; i++) set_level(i, 8);
        foreach (order[b]) run_block(order[b]);
        expect_idle("masked_src2", 4);
    endtask

    task automatic test_protocol_err();
        do_reset();
        drive_cycle(1'b1, 1'b0);
        #1;
        checks++;
        if (src_rd !== '0) begin
            errors++;
            $display("FAIL idle_read_src_rd: got %b want 0", src_rd);
        end
        sb.push_back(16'h0000);
        drive_cycle(1'b0, 1'b0);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL idle_read_err: got %b want 1", protocol_err);
        end
        set_level(3, THRESH);
        run_block(1 + 2);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", protocol_err);
        end
        do_reset();
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL idle_strobe_err: got %b want 1", protocol_err);
        end
        do_reset();
        #1;
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b want 0", protocol_err);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int n;
        do_reset();
        for (int i = 0; i < NSRC; i++) set_level(i, 8);
        wait_ready(n);
        checks++;
        if (grant_id !== 2'd1 || n != 1) begin
            errors++;
            $display("FAIL mid_grant: got grant %0d after %0d cycles want 1 after 1", grant_id, n);
        end
        drive_cycle(1'b0, 1'b1);
        read_word(1, 0);
        read_word(1, 1);
        drive_cycle(1'b1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({pipe_out_ready, src_rd, pipe_out_data, grant_id, block_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: ready=%b rd=%b data=%h grant=%0d bc=%0d want all 0",
                     pipe_out_ready, src_rd, pipe_out_data, grant_id, block_count);
        end
        pipe_out_read = 1'b0;
        rd_prev       = 1'b0;
        sb.delete();
        @(negedge clk);
        reset      = 1'b0;
        exp_blocks = 0;
        run_block(1);
    endtask

`ifdef PIPE_OUT_ARB_TAG_EN
    task automatic test_tag();
        do_reset();
        set_level(1, THRESH);
        run_block(1);
        set_level(1, THRESH);
        run_block(1);
        checks++;
        if (exp_blocks != 2 || block_count !== 16'd2) begin
            errors++;
            $display("FAIL tag_blocks: got %0d want 2", block_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_protocol_err();
        test_reset_mid_xfer();
`ifdef PIPE_OUT_ARB_TAG_EN
        test_tag();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/pipe_out_arbiter.md
# pipe_out_arbiter

Block-granular round-robin arbiter that shares one block-throttled pipe-out endpoint (16-bit, host-read) between up to four source FIFOs. The host always reads whole blocks of BLOCK_WORDS words. Each block is drawn entirely from one source, and a source is granted only when it holds at least one full block. The block sits between the capture/generator FIFOs and the pipe-out endpoint, on the host interface clock.

## Interface
- NSRC, 4: number of sources, 2..4.
- BLOCK_WORDS, 256: words per host block, power of two, 2..1024.
- LEVEL_W, 11: width of each source level field; must hold BLOCK_WORDS.
- clk  in  1  host interface clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  global arbitration enable (host wire bit).
- src_en  in  NSRC  per-source eligibility mask.
- src_level  in  NSRC*LEVEL_W  words available in source i, field i = [i*LEVEL_W +: LEVEL_W].
- src_rd  out  NSRC  read strobe to source i; standard FIFO, data valid 1 cycle after strobe.
- src_data  in  NSRC*16  source read data, field i = [i*16 +: 16].
- pipe_out_read  in  1  endpoint read strobe; data is due on the next cycle.
- pipe_out_blockstrobe  in  1  endpoint block-start pulse, 1 cycle before the first read of a block.
- pipe_out_ready  out  1  endpoint ready: a full block is committed.
- pipe_out_data  out  16  endpoint read data.
- grant_id  out  2  currently/last granted source.
- block_count  out  16  blocks completed, wraps 0xFFFF->0.
- protocol_err  out  1  sticky: read outside a block, or blockstrobe outside READY.

## Operation
- States: IDLE, READY, XFER. Reset values: state IDLE, grant_id 0, pipe_out_ready 0, src_rd 0, pipe_out_data 0, block_count 0, protocol_err 0, word counter 0.
- Eligible(i) = src_en[i] && src_level[i] >= BLOCK_WORDS.
- IDLE: if enable and any source is eligible, register grant_id as the first eligible source scanning grant_id+1, grant_id+2, … modulo NSRC (the previous grantee has lowest priority), then go to READY. Otherwise stay in IDLE.
- READY:
  - pipe_out_ready=1.
  - On pipe_out_blockstrobe, go to XFER and clear the word counter.
  - enable=0 in READY returns to IDLE; grant_id is kept.
- XFER:
  - pipe_out_ready=1.
  - src_rd[grant_id] = pipe_out_read, combinationally; all other src_rd bits stay 0.
  - Each read increments the word counter.
  - On the read making the count BLOCK_WORDS: block_count+1, then go to IDLE. pipe_out_ready falls on the following cycle.
  - enable and src_en are ignored until the block completes.
- Data path: pipe_out_data = src_data[data_sel], registered as 0 when no read occurred on the previous cycle. data_sel is grant_id delayed one clock, so the last word of a block still comes from the old source when a new grant is registered.
- Errors:
  - pipe_out_read in IDLE/READY: protocol_err=1, no src_rd, pipe_out_data=0 next cycle.
  - blockstrobe in IDLE/XFER: protocol_err=1, no state change.
  - protocol_err clears only on reset.
- Since src_level can only fall through our reads, a committed grant never underflows.

## Timing
- Eligibility to pipe_out_ready high: 1 cycle (IDLE->READY registered).
- pipe_out_read at cycle t -> pipe_out_data valid at t+1. The source FIFO's 1-cycle latency meets the endpoint requirement.
- Back-to-back: the last read of block k at t; IDLE at t+1; READY (ready high) at t+2 if a source is eligible. pipe_out_ready low for exactly 1 cycle (t+1) between blocks.
- Asynchronous reset mid-XFER: all outputs go to reset values immediately. The partial block is abandoned; the source keeps its unread words.

## Configuration
- PIPE_OUT_ARB_TAG_EN defined:
  - The first word of every block is the tag {grant_id[1:0], 2'b00, seq[11:0]}; seq is a per-arbiter 12-bit block counter (= block_count[11:0]).
  - The tag read does not assert src_rd; the remaining BLOCK_WORDS-1 reads come from the source.
  - Eligibility threshold becomes BLOCK_WORDS-1.
- Not defined: all BLOCK_WORDS words come from the source; no tag logic is present.

## Test plan
- NSRC=4, BLOCK_WORDS=4, only src 2 level=4, enable=1 -> ready after 1 cycle, grant_id=2; strobe + 4 reads -> src_rd[2] pulses 4 times, data = src 2 words in order, block_count=1.
- All sources level=8 -> grants 1,2,3,0,1,… (from reset grant 0), one block each, ready low exactly 1 cycle between blocks.
- src_en=4'b1011 with all sources full -> source 2 is never granted.
- pipe_out_read while IDLE -> protocol_err=1, no src_rd, data 0; it stays 1 until reset.
- Reset asserted after 2 of 4 reads -> outputs 0 immediately, state IDLE; the next grant restarts from source 1.
- With PIPE_OUT_ARB_TAG_EN, BLOCK_WORDS=4, src 1 level=3 -> first word 0x4000 (seq 0), then 3 source words; second block tag 0x4001.
